// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//
// Round-robin arbiter in front of the shared 8-bit bus register pipeline
// (A -> B -> C). At most one requester is granted per cycle, and its word is
// driven onto pipeline input A. A valid/tag shadow pipeline runs alongside the
// two external data register stages, so each word that comes out of stage C
// is presented together with the index of the requester that owns it.
//
// Optional feature (compile-time macro BUS_ARB_LOCK_EN):
//   When defined, a requester that wins while asserting lock[k] keeps the bus
//   for up to MAXBURST consecutive grants (ARB/BURST state machine). When
//   undefined, the lock port does not exist and grants rotate strictly.
//
// Ports
//   ck         in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   req        in   [NREQ]     per-requester request, held until granted
//   req_data   in   [NREQ*DW]  requester i word in bits [i*DW +: DW]
//   gnt        out  [NREQ]     one-hot grant (combinational)
//   bus_a      out  [DW]       word to pipeline input A (zeros when idle)
//   bus_c      in   [DW]       word from pipeline output C
//   out_valid  out             bus_c carries a granted word this cycle
//   out_tag    out  [TW]       owner index of the word on bus_c
//   out_data   out  [DW]       bus_c passthrough
//   lock       in   [NREQ]     burst-lock request (BUS_ARB_LOCK_EN only)
// -----------------------------------------------------------------------------
//
// state | meaning (BUS_ARB_LOCK_EN only)
// ------+-----------------------------------------------------------
// ARB   | normal round-robin search starting at ptr
// BURST | grants held on owner while req[owner] & lock[owner] and
//       | bcnt < MAXBURST; the exit cycle arbitrates from owner+1
// -----------------------------------------------------------------------------

module bus_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int TW       = $clog2(NREQ),
  parameter int MAXBURST = 4
) (
  input  logic               ck,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      bus_a,
  input  logic [DW-1:0]      bus_c,
  output logic               out_valid,
  output logic [TW-1:0]      out_tag,
  output logic [DW-1:0]      out_data
`ifdef BUS_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]    lock
`endif
);

  if (NREQ < 2 || NREQ > 8 || MAXBURST < 1) begin : g_bad_param
    $error("bus_rr_arbiter: NREQ must be 2..8 and MAXBURST >= 1");
  end

  localparam logic [TW-1:0] LAST_IDX = TW'(NREQ - 1);

  function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + TW'(1);
  endfunction

  logic [TW-1:0] ptr;
  logic [TW-1:0] ptr_nxt;
  logic [TW-1:0] base;
  logic          win_found;
  logic [TW-1:0] win_idx;
  logic          sel_vld;
  logic [TW-1:0] sel_idx;

  logic          v1;
  logic          v2;
  logic [TW-1:0] tag1;
  logic [TW-1:0] tag2;

  // Round-robin search: first set request at or after base, wrapping.
  // csum is one bit wider than an index so base+offset never overflows
  // before the modulo correction.
  logic [TW:0]   csum;
  logic [TW-1:0] cidx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    csum      = '0;
    cidx      = '0;
    for (int off = 0; off < NREQ; off++) begin
      csum = {1'b0, base} + (TW+1)'(off);
      if (csum >= (TW+1)'(NREQ)) begin
        csum = csum - (TW+1)'(NREQ);
      end
      cidx = csum[TW-1:0];
      if (!win_found && req[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

`ifdef BUS_ARB_LOCK_EN

  localparam int BCW = $clog2(MAXBURST + 1);

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [TW-1:0]  owner;
  logic [TW-1:0]  owner_nxt;
  logic [BCW-1:0] bcnt;
  logic [BCW-1:0] bcnt_nxt;
  logic           hold;

  // Owner keeps the bus only while it still asks for it and has budget left.
  assign hold = (state == BURST) && req[owner] && lock[owner] &&
                (bcnt != BCW'(MAXBURST));

  // Leaving BURST arbitrates from the slot after the owner so the others
  // get their turn first; otherwise search from ptr.
  assign base = (state == BURST) ? wrap_inc(owner) : ptr;

  // State register
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state <= ARB;
      owner <= '0;
      bcnt  <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      bcnt  <= bcnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state and grant decision
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    bcnt_nxt  = bcnt;
    ptr_nxt   = ptr;
    sel_vld   = 1'b0;
    sel_idx   = '0;
    if (hold) begin
      sel_vld  = 1'b1;
      sel_idx  = owner;
      bcnt_nxt = bcnt + BCW'(1);
    end else begin
      sel_vld   = win_found;
      sel_idx   = win_idx;
      state_nxt = ARB;
      bcnt_nxt  = '0;
      if (state == BURST) begin
        ptr_nxt = wrap_inc(owner);
      end
      if (win_found) begin
        if (lock[win_idx]) begin
          // Pointer stays put on burst entry; it moves past the owner on exit.
          state_nxt = BURST;
          owner_nxt = win_idx;
          bcnt_nxt  = BCW'(1);
        end else begin
          ptr_nxt = wrap_inc(win_idx);
        end
      end
    end
  end

`else

  assign base = ptr;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  always_comb begin
    sel_vld = win_found;
    sel_idx = win_idx;
    ptr_nxt = win_found ? wrap_inc(win_idx) : ptr;
  end

`endif

  // Output decode: one-hot grant and the winner's word. Held at zero during
  // reset so nothing enters the pipeline while the arbiter is cleared.
  always_comb begin
    gnt   = '0;
    bus_a = '0;
    if (rst && sel_vld) begin
      gnt[sel_idx] = 1'b1;
      bus_a        = req_data[int'(sel_idx)*DW +: DW];
    end
  end

  // Shadow pipeline, one stage per external data register (B, C).
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      v1   <= sel_vld;
      tag1 <= sel_idx;
      v2   <= v1;
      tag2 <= tag1;
    end
  end

  assign out_valid = v2;
  assign out_tag   = tag2;
  assign out_data  = bus_c;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
module tb_bus_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TW   = 2;

  logic               ck = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      bus_a;
  logic [DW-1:0]      pipe_b;
  logic [DW-1:0]      bus_c;
  logic               out_valid;
  logic [TW-1:0]      out_tag;
  logic [DW-1:0]      out_data;
`ifdef BUS_ARB_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bus_rr_arbiter #(
    .NREQ(NREQ), .DW(DW), .TW(TW), .MAXBURST(4)
  ) dut (
    .ck        (ck),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .bus_a     (bus_a),
    .bus_c     (bus_c),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .out_data  (out_data)
`ifdef BUS_ARB_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  always #5 ck = ~ck;

  // External two-stage bus register pipeline A -> B -> C.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      pipe_b <= '0;
      bus_c  <= '0;
    end else begin
      pipe_b <= bus_a;
      bus_c  <= pipe_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge ck);
    #1;
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [TW-1:0] tg,
                           input logic [DW-1:0] dat);
    check({tag, "_valid"}, 32'(out_valid), 32'(vld));
    if (vld) begin
      check({tag, "_tag"}, 32'(out_tag), 32'(tg));
      check({tag, "_data"}, 32'(out_data), 32'(dat));
    end
  endtask

  logic [NREQ-1:0] exp_g;
  logic [DW-1:0]   exp_d;
`ifdef BUS_ARB_LOCK_EN
  logic [NREQ-1:0] burst_exp [6];
`endif

  initial begin
    // 1. reset with all requests pending
    req      = 4'hF;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef BUS_ARB_LOCK_EN
    lock     = '0;
`endif
    #12;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_bus_a", 32'(bus_a), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_tag", 32'(out_tag), 32'h0);
    step;
    check("rst_gnt_edge", 32'(gnt), 32'h0);
    rst = 1'b1;
    #1;

    // 3. fairness with all four requesting; first grant goes to 0
    for (int i = 0; i < 8; i++) begin
      exp_g = 4'b0001 << (i % 4);
      exp_d = 8'h10 + 8'(i % 4);
      check("fair_gnt", 32'(gnt), 32'(exp_g));
      check("fair_bus_a", 32'(bus_a), 32'(exp_d));
      if (i >= 2) begin
        check_out("fair_out", 1'b1, TW'((i - 2) % 4), 8'h10 + 8'((i - 2) % 4));
      end else begin
        check("fair_out_valid_lat", 32'(out_valid), 32'h0);
      end
      step;
    end
    req = '0;
    #1;
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_bus_a", 32'(bus_a), 32'h0);
    check_out("drain0", 1'b1, 2'd2, 8'h12);
    step;
    check_out("drain1", 1'b1, 2'd3, 8'h13);
    step;
    check_out("drain2", 1'b0, 2'd0, 8'h00);

    // 2. single requester, req dropped right after the grant
    req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    req      = 4'b0100;
    #1;
    check("single_gnt", 32'(gnt), 32'b0100);
    check("single_bus_a", 32'(bus_a), 32'hA5);
    step;
    req = '0;
    #1;
    check("single_t1_gnt", 32'(gnt), 32'h0);
    check("single_t1_valid", 32'(out_valid), 32'h0);
    step;
    check_out("single_t2", 1'b1, 2'd2, 8'hA5);

    // 4. wrap from ptr=3, then an idle slot, then ptr must be unchanged
    req = 4'b1001;
    #1;
    check("wrap_gnt3", 32'(gnt), 32'b1000);
    check("wrap_bus_a3", 32'(bus_a), 32'h13);
    step;
    req = 4'b0001;
    #1;
    check("wrap_gnt0", 32'(gnt), 32'b0001);
    check("wrap_bus_a0", 32'(bus_a), 32'h10);
    check("wrap_prev_idle", 32'(out_valid), 32'h0);
    step;
    req = '0;
    #1;
    check("wrap_idle_gnt", 32'(gnt), 32'h0);
    check("wrap_idle_bus_a", 32'(bus_a), 32'h0);
    check_out("wrap_out3", 1'b1, 2'd3, 8'h13);
    step;
    check_out("wrap_out0", 1'b1, 2'd0, 8'h10);
    step;
    check("wrap_idle_valid", 32'(out_valid), 32'h0);
    check("wrap_idle_slot", 32'(out_data), 32'h0);
    req = 4'b0011;
    #1;
    check("ptr_held_gnt", 32'(gnt), 32'b0010);
    step;

    // 5. reset one cycle after granting 8'h3C
    req_data = {8'h13, 8'h3C, 8'h11, 8'h10};
    req      = 4'b0100;
    #1;
    check("mid_gnt", 32'(gnt), 32'b0100);
    check("mid_bus_a", 32'(bus_a), 32'h3C);
    step;
    rst = 1'b0;
    req = '0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    step;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("mid_post_valid", 32'(out_valid), 32'h0);
      check("mid_no_3c", 32'(out_valid && (out_data == 8'h3C)), 32'h0);
    end
    req = 4'b0110;
    #1;
    check("post_rst_gnt", 32'(gnt), 32'b0010);
    step;
    req = '0;
    #1;
    check("post_rst_t1_valid", 32'(out_valid), 32'h0);
    step;
    check_out("post_rst_t2", 1'b1, 2'd1, 8'h11);

`ifdef BUS_ARB_LOCK_EN
    // 6. burst lock on requester 1, MAXBURST=4, starting with ptr=1
    rst = 1'b0;
    #2;
    rst = 1'b1;
    req  = 4'b0001;
    lock = 4'b0010;
    #1;
    check("lock_pre_gnt", 32'(gnt), 32'b0001);
    step;
    burst_exp[0] = 4'b0010;
    burst_exp[1] = 4'b0010;
    burst_exp[2] = 4'b0010;
    burst_exp[3] = 4'b0010;
    burst_exp[4] = 4'b0001;
    burst_exp[5] = 4'b0010;
    req = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("lock_gnt", 32'(gnt), 32'(burst_exp[i]));
      step;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
